// File: rtl/accu_collector_pkg.sv
// accu_collector shared definitions: FSM states, geometry,
// BRAM address-field layout common with the feature loader, ReLU.
package accu_pkg;

  localparam int LANES      = 16;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 17;

  localparam int REGION_LSB = 15;
  localparam int REGION_W   = 2;
  localparam int CH_LSB     = 6;
  localparam int CH_W       = 4;
  localparam int POS_LSB    = 0;
  localparam int POS_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] make_addr(
    input logic [REGION_W-1:0] region,
    input logic [CH_W-1:0]     ch,
    input logic [POS_W-1:0]    pos
  );
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[REGION_LSB +: REGION_W] = region;
    a[CH_LSB +: CH_W]         = ch;
    a[POS_LSB +: POS_W]       = pos;
    return a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] relu(
    input logic [DATA_WIDTH-1:0] w
  );
    return w[DATA_WIDTH-1] ? '0 : w;
  endfunction

endpackage

// File: rtl/accu_collector_lane_fifo.sv
// Per-lane skew FIFO: pointer-based, first-word fall-through,
// push is dropped when full, flush empties it in one cycle.
module lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Read/write pointers; the extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/accu_collector.sv
// Deskews systolic column outputs into rows, applies ReLU and
// streams each row into the feature BRAM byte-write port.
module accu_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [1:0]                       nth_conv_i,
  input  logic [5:0]                       out_len_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] accu_data_i,
  input  logic [LANES-1:0]                 accu_valid_i,
  output logic                             wea_o,
  output logic [ADDR_WIDTH-1:0]            addra_o,
  output logic [DATA_WIDTH-1:0]            dia_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);

  import accu_pkg::*;

  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  state_e                  state_q;
  logic [1:0]              nth_q;
  logic [5:0]              len_q;
  logic [5:0]              pos_q;
  logic [LANE_W-1:0]       lane_q;
  logic                    ovf_q;
  logic                    wea_q;
  logic [ADDR_WIDTH-1:0]   addra_q;
  logic [DATA_WIDTH-1:0]   dia_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   row_q [LANES];

  logic [LANES-1:0]        push_w;
  logic [LANES-1:0]        full_w;
  logic [LANES-1:0]        empty_w;
  logic [DATA_WIDTH-1:0]   fifo_dout_w [LANES];
  logic                    capture;
  logic                    flush;
  logic                    all_ne;
  logic                    row_end;
  logic                    load;
  logic                    ovf_set;

  assign capture = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign flush   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign all_ne  = ~|empty_w;
  assign row_end = (state_q == S_WRITE) && (lane_q == LANE_LAST);
  assign ovf_set = capture && |(accu_valid_i & full_w);

  // Pop every lane at once when a full row is ready to be consumed
  always_comb begin
    load = 1'b0;
    if (state_q == S_COLLECT)
      load = all_ne;
    else if (row_end && (pos_q != len_q))
      load = all_ne;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign push_w[k] = capture && accu_valid_i[k];

    lane_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .push_i  (push_w[k]),
      .data_i  (accu_data_i[k]),
      .pop_i   (load),
      .data_o  (fifo_dout_w[k]),
      .full_o  (full_w[k]),
      .empty_o (empty_w[k])
    );
  end

  // Row register captures the aligned heads of all lane FIFOs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) row_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < LANES; i++) row_q[i] <= fifo_dout_w[i];
    end
  end

  // Control FSM, address generator and registered BRAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nth_q   <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      lane_q  <= '0;
      ovf_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dia_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      wea_q  <= 1'b0;
      done_q <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            nth_q   <= nth_conv_i;
            len_q   <= out_len_i;
            pos_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (load) begin
            lane_q  <= '0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          wea_q   <= 1'b1;
          addra_q <= ADDR_WIDTH'(make_addr(nth_q, CH_W'(lane_q), pos_q));
          dia_q   <= relu(row_q[lane_q]);
          if (lane_q == LANE_LAST) begin
            if (pos_q == len_q) begin
              state_q <= S_DONE;
            end else begin
              pos_q <= pos_q + 1'b1;
              if (load) lane_q  <= '0;
              else      state_q <= S_COLLECT;
            end
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wea_o      = wea_q;
  assign addra_o    = addra_q;
  assign dia_o      = dia_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign busy_o     = capture;

endmodule

// File: tb/tb_accu_collector.sv
// Self-checking bench for accu_collector: table vectors, directed
// corner sequences and randomized planes against a write-list model.
module tb_accu_collector;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int AW    = 17;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start_i;
  logic [1:0]               nth_conv_i;
  logic [5:0]               out_len_i;
  logic [LANES-1:0][DW-1:0] accu_data_i;
  logic [LANES-1:0]         accu_valid_i;
  logic                     wea_o;
  logic [AW-1:0]            addra_o;
  logic [DW-1:0]            dia_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     overflow_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  int            got_c[$];
  int            done_cnt = 0;
  int            done_cyc = 0;

  logic [DW-1:0] rowdata [64][LANES];
  int            base_w;
  int            base_d;
  int            v15_edge;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } relu_vec_t;
  relu_vec_t tab [LANES];

  accu_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .nth_conv_i   (nth_conv_i),
    .out_len_i    (out_len_i),
    .accu_data_i  (accu_data_i),
    .accu_valid_i (accu_valid_i),
    .wea_o        (wea_o),
    .addra_o      (addra_o),
    .dia_o        (dia_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wea_o === 1'b1) begin
      got_a.push_back(addra_o);
      got_d.push_back(dia_o);
      got_c.push_back(cyc);
    end
    if (done_o === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    if (i >= 0 && i < got_a.size()) return 32'(got_a[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] qd(input int i);
    if (i >= 0 && i < got_d.size()) return 32'(got_d[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] qc(input int i);
    if (i >= 0 && i < got_c.size()) return got_c[i];
    return 'x;
  endfunction

  task automatic fill_rows(input int nrows);
    for (int r = 0; r < nrows; r++)
      for (int k = 0; k < LANES; k++)
        rowdata[r][k] = 8'($urandom);
  endtask

  task automatic start_plane(input logic [1:0] nth,
                             input logic [5:0] len);
    base_w = got_a.size();
    base_d = done_cnt;
    start_i    = 1'b1;
    nth_conv_i = nth;
    out_len_i  = len;
    @(posedge clk); #1;
    start_i    = 1'b0;
    nth_conv_i = 2'($urandom);
    out_len_i  = 6'($urandom);
  endtask

  // Row r, lane k is presented at cycle r*gap + k
  task automatic feed(input int nrows_m1, input int gap);
    int total;
    total = nrows_m1 * gap + LANES;
    for (int c = 0; c < total; c++) begin
      for (int k = 0; k < LANES; k++) begin
        int d;
        d = c - k;
        if (d >= 0 && d % gap == 0 && d / gap <= nrows_m1) begin
          accu_valid_i[k] = 1'b1;
          accu_data_i[k]  = rowdata[d / gap][k];
        end else begin
          accu_valid_i[k] = 1'b0;
          accu_data_i[k]  = 8'($urandom);
        end
      end
      @(posedge clk); #1;
      if (c == LANES - 1) v15_edge = cyc;
    end
    accu_valid_i = '0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == base_d && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " done_seen"}, 32'(done_cnt != base_d), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: every (pos, lane) in order, address from the field
  // layout, data through ReLU
  task automatic check_plane(input string name, input int nth,
                             input int len);
    int n;
    int got_n;
    int bad;
    n     = (len + 1) * LANES;
    got_n = got_a.size() - base_w;
    bad   = -1;
    chk({name, " writes"}, got_n, n);
    if (got_n == n) begin
      for (int p = 0; p <= len; p++) begin
        for (int l = 0; l < LANES; l++) begin
          int i;
          int ea;
          logic [7:0] ed;
          i  = base_w + p * LANES + l;
          ea = nth * 32768 + l * 64 + p;
          ed = (rowdata[p][l] >= 8'h80) ? 8'h00 : rowdata[p][l];
          if (bad < 0 && (got_a[i] !== AW'(ea) || got_d[i] !== ed))
            bad = p * LANES + l;
        end
      end
    end
    chk({name, " first_bad_idx"}, bad, -1);
    chk({name, " done_pulses"}, done_cnt - base_d, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    nth_conv_i   = '0;
    out_len_i    = '0;
    accu_valid_i = '0;
    accu_data_i  = '0;

    tab[0]  = '{8'h80, 8'h00}; tab[1]  = '{8'hFF, 8'h00};
    tab[2]  = '{8'h7F, 8'h7F}; tab[3]  = '{8'h00, 8'h00};
    tab[4]  = '{8'h01, 8'h01}; tab[5]  = '{8'h40, 8'h40};
    tab[6]  = '{8'hC0, 8'h00}; tab[7]  = '{8'h81, 8'h00};
    tab[8]  = '{8'h7E, 8'h7E}; tab[9]  = '{8'h10, 8'h10};
    tab[10] = '{8'hA5, 8'h00}; tab[11] = '{8'h5A, 8'h5A};
    tab[12] = '{8'hFE, 8'h00}; tab[13] = '{8'h02, 8'h02};
    tab[14] = '{8'h3C, 8'h3C}; tab[15] = '{8'hE0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst wea", 32'(wea_o), 0);
    chk("rst addra", 32'(addra_o), 0);
    chk("rst dia", 32'(dia_o), 0);
    chk("rst busy", 32'(busy_o), 0);
    chk("rst done", 32'(done_o), 0);
    chk("rst overflow", 32'(overflow_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single skewed row, region 1, data k+1
    for (int k = 0; k < LANES; k++) rowdata[0][k] = 8'(k + 1);
    start_plane(2'd1, 6'd0);
    chk("single busy", 32'(busy_o), 1);
    feed(0, 16);
    wait_done("single");
    check_plane("single", 1, 0);
    chk("single addr0", qa(base_w), 32'h08000);
    chk("single addr15", qa(base_w + 15), 32'h083C0);
    chk("single latency", qc(base_w), 32'(v15_edge + 2));
    chk("single done_timing", 32'(done_cyc), qc(base_w + 15) + 1);
    chk("single busy_after", 32'(busy_o), 0);

    // ReLU vector table, one row
    for (int k = 0; k < LANES; k++) rowdata[0][k] = tab[k].din;
    start_plane(2'd0, 6'd0);
    feed(0, 16);
    wait_done("relu");
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("relu dia lane%0d", k), qd(base_w + k),
          32'(tab[k].exp));
      chk($sformatf("relu addr lane%0d", k), qa(base_w + k),
          32'(k * 64));
    end

    // Back-to-back rows, no bubble
    fill_rows(4);
    start_plane(2'd2, 6'd3);
    feed(3, 16);
    wait_done("b2b");
    check_plane("b2b", 2, 3);
    chk("b2b span", qc(base_w + 63) - qc(base_w), 32'd63);
    chk("b2b overflow", 32'(overflow_o), 0);

    // Overflow: lane 0 alone five times into a depth-4 FIFO
    start_plane(2'd0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      accu_valid_i    = '0;
      accu_valid_i[0] = 1'b1;
      accu_data_i[0]  = 8'(i + 1);
      @(posedge clk); #1;
    end
    accu_valid_i = '0;
    chk("ovf set", 32'(overflow_o), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf sticky", 32'(overflow_o), 1);
    accu_valid_i        = '1;
    accu_valid_i[0]     = 1'b0;
    @(posedge clk); #1;
    accu_valid_i = '0;
    wait_done("ovf_plane");
    chk("ovf sticky_idle", 32'(overflow_o), 1);
    fill_rows(1);
    start_plane(2'd3, 6'd0);
    chk("ovf cleared_by_start", 32'(overflow_o), 0);
    feed(0, 16);
    wait_done("post_ovf");
    check_plane("post_ovf", 3, 0);

    // Valids in IDLE are ignored; start during WRITE is ignored
    accu_valid_i = '1;
    for (int k = 0; k < LANES; k++) accu_data_i[k] = 8'h2A;
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", 32'(busy_o), 0);
    accu_valid_i = '0;
    fill_rows(1);
    start_plane(2'd1, 6'd0);
    feed(0, 16);
    repeat (2) @(posedge clk);
    #1;
    start_i    = 1'b1;
    nth_conv_i = 2'd2;
    out_len_i  = 6'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done("ignored");
    check_plane("ignored", 1, 0);

    // Reset in the middle of a write burst
    fill_rows(2);
    start_plane(2'd2, 6'd1);
    feed(0, 16);
    for (int k = 0; k < 4; k++) begin
      accu_valid_i    = '0;
      accu_valid_i[k] = 1'b1;
      accu_data_i[k]  = 8'h55;
      @(posedge clk); #1;
    end
    accu_valid_i = '0;
    chk("midrst in_write", 32'(wea_o), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst wea", 32'(wea_o), 0);
    chk("midrst addra", 32'(addra_o), 0);
    chk("midrst dia", 32'(dia_o), 0);
    chk("midrst busy", 32'(busy_o), 0);
    chk("midrst done", 32'(done_o), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_rows(1);
    start_plane(2'd0, 6'd0);
    feed(0, 16);
    wait_done("after_rst");
    check_plane("after_rst", 0, 0);

    // Randomized planes against the write-list model
    for (int p = 0; p < 6; p++) begin
      int nth;
      int len;
      int gap;
      nth = $urandom_range(0, 3);
      len = $urandom_range(0, 5);
      gap = $urandom_range(16, 22);
      fill_rows(len + 1);
      start_plane(2'(nth), 6'(len));
      feed(len, gap);
      wait_done($sformatf("rand%0d", p));
      check_plane($sformatf("rand%0d", p), nth, len);
      chk($sformatf("rand%0d overflow", p), 32'(overflow_o), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accu_collector.md
# accu_collector

Downstream stage of the systolic-array top. Captures the 16 skewed per-column accumulator outputs (`accu_data`/`accu_valid`, lane k arriving k cycles after lane 0), realigns them into rows, and applies ReLU. It then serialises each row into the same `wea`/`addra`/`dia` byte-write format the array's feature BRAM accepts, so one conv layer's output lands directly as the next layer's input.

## Interface
- `DATA_WIDTH`, 8, accumulator/output word width (two's complement)
- `LANES`, 16, number of array columns
- `ADDR_WIDTH`, 17, write-address width
- `FIFO_DEPTH`, 4, per-lane skew FIFO depth (power of two)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start_i` in 1: one-cycle pulse; arms collection of one conv output plane
- `nth_conv_i` in 2: destination region, latched on `start_i`
- `out_len_i` in 6: rows to collect minus one (0..63), latched on `start_i`
- `accu_data_i` in `DATA_WIDTH` × `LANES`: per-lane accumulator result
- `accu_valid_i` in 1 × `LANES`: per-lane valid strobe
- `wea_o` out 1: write enable to feature BRAM
- `addra_o` out `ADDR_WIDTH`: write address
- `dia_o` out `DATA_WIDTH`: write data
- `busy_o` out 1: high outside IDLE/DONE
- `done_o` out 1: one-cycle pulse after the last write
- `overflow_o` out 1: sticky; a valid sample hit a full lane FIFO

## Operation
- **FSM states:** IDLE, COLLECT, WRITE, DONE.
- **IDLE:**
  - `start_i` latches `nth_conv_i`, `out_len_i`, clears row counter `pos` and `overflow_o`, then goes to COLLECT.
  - `accu_valid_i` is ignored in IDLE; nothing is pushed.
- **Lane capture:** in COLLECT/WRITE, each asserted `accu_valid_i[k]` pushes `accu_data_i[k]` into lane FIFO k.
  - If that FIFO is full, the sample is dropped and `overflow_o` is set.
- **COLLECT:** when all `LANES` FIFOs are non-empty, all are popped simultaneously into the row register, `lane` is cleared to 0, and the FSM goes to WRITE.
- **WRITE:** one word per cycle, `lane` 0..`LANES-1`.
  - `dia_o` = 0 if the word's MSB is 1, else the word (ReLU).
  - `addra_o` = {`nth_conv` (2b), 5'b0, `lane` (4b), `pos` (6b)}. Channel sits in [9:6] and position in [5:0], the array's loader layout.
- **End of row (`lane` = `LANES-1`):**
  - If `pos` = `out_len`, go to DONE.
  - Else `pos`++. If all FIFOs are non-empty in that same cycle, pop and reload the row and stay in WRITE with `lane`=0 (back-to-back rows). Otherwise go to COLLECT.
- **DONE:** `done_o` = 1 for one cycle, then IDLE. Leftover FIFO contents are flushed on entry to IDLE.
- **Ignored start:** `start_i` outside IDLE has no effect.
- **Reset mid-operation:** returns the FSM to IDLE, empties all FIFOs, and zeroes all outputs. No partial write completes.

## Timing
- **Reset values:** `wea_o`=0, `addra_o`=0, `dia_o`=0, `busy_o`=0, `done_o`=0, `overflow_o`=0.
- **Registered outputs:** `wea_o`, `addra_o`, `dia_o` are registered and reflect the WRITE state of the previous cycle.
- **Latency:** first `wea_o` of a row is asserted after the 2nd rising edge following the edge that sampled the final lane's valid (push → pop/load → output register).
- **Throughput:** one row per `LANES` cycles sustained. Upstream may not exceed this rate.
  - With skew ≤ `LANES-1`, each FIFO holds at most 2 entries. Depth 4 leaves margin.
- **Write burst:** exactly `LANES`×(`out_len`+1) `wea_o` pulses per start.
- **`done_o` timing:** rises the cycle after the final `wea_o` cycle.

## Structure
- **Package `accu_pkg`:** FSM state enum, `LANES`, `DATA_WIDTH`, the address-field positions ([16:15] region, [9:6] channel, [5:0] position) shared with the loader, and a `relu` function.
- **Sub-module `lane_fifo`:** parameterised synchronous FIFO with push, pop, full, empty and flush, instantiated `LANES` times via generate. The FSM, row register and address generator live in the top.

## Test plan
- **Reset mid-WRITE:** assert `rst_n`=0 during WRITE → all outputs 0 immediately. A subsequent `start_i` gives a clean run with no stale data written.
- **Single row, skewed input:** `out_len_i`=0, `nth_conv_i`=1, lane k data = k+1, valid at cycle t0+k.
  - → 16 writes, `addra_o` = 0x08000 + (k<<6), `dia_o` = k+1.
  - → first `wea_o` 2 edges after lane 15's valid edge; `done_o` one cycle after the last write.
- **ReLU:** lane data 0x80, 0xFF, 0x7F, 0x00 → written values 0, 0, 0x7F, 0.
- **Back-to-back rows:** `out_len_i`=3, rows every 16 cycles → 64 consecutive `wea_o` cycles with no bubble; `pos` field 0..3; one `done_o`.
- **Overflow:** lane 0 valid on 5 consecutive cycles before lane 1 delivers anything → `overflow_o`=1 and it stays 1 until the next `start_i`.
- **Ignored inputs:** valid pulses in IDLE and a `start_i` during WRITE → no FIFO push, no change to the in-flight address sequence.
